// File: rtl/du_rx_assembler.sv
`default_nettype none
// ============================================================================
// Module   : du_rx_assembler
// Purpose  : Upstream stage of the debug-unit FSM. Turns UART byte strobes
//            into an instruction count, a stream of little-endian instruction
//            words (each one emitted as a one-cycle program-memory write), and
//            a handshaked operation-mode byte.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clock                 in   1        system clock, posedge
//   i_reset                 in   1        synchronous reset, active-low
//   i_rx_done               in   1        one-cycle strobe, i_rx_data valid
//   i_rx_data               in   N_BITS   received byte
//   i_mode_ack              in   1        debug unit consumed the mode byte
//   o_number_instructions   out  N_BITS   captured instruction count
//   o_ready_number_instr    out  1        level: count captured
//   o_instruction           out  NB_DATA  last assembled word
//   o_ready_full_inst       out  1        one-cycle pulse: write o_instruction
//   o_addr_instruction      out  ADDR_W   words committed so far (wraps)
//   o_ready_all_instr_send  out  1        level: every word received
//   o_mode_operate          out  N_BITS   captured mode byte
//   o_ready_mode_operate    out  1        level: mode valid until i_mode_ack
//   o_error                 out  1        sticky checksum error
//   o_state                 out  3        FSM state for debug
// Build option
//   DU_RX_CHECKSUM_EN : when defined, one XOR checksum byte follows the last
//                       instruction byte and o_error is live; otherwise the
//                       byte after the last instruction is the mode byte and
//                       o_error is tied low.
// ============================================================================
module du_rx_assembler #(
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8,
    parameter int N_BYTES = NB_DATA / N_BITS,
    parameter int ADDR_W  = 7
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [N_BITS-1:0]   i_rx_data,
    input  logic                i_mode_ack,
    output logic [N_BITS-1:0]   o_number_instructions,
    output logic                o_ready_number_instr,
    output logic [NB_DATA-1:0]  o_instruction,
    output logic                o_ready_full_inst,
    output logic [ADDR_W-1:0]   o_addr_instruction,
    output logic                o_ready_all_instr_send,
    output logic [N_BITS-1:0]   o_mode_operate,
    output logic                o_ready_mode_operate,
    output logic                o_error,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        GET_COUNT  = 3'd0,
        GET_WORD   = 3'd1,
        CHECK      = 3'd2,
        WAIT_MODE  = 3'd3,
        MODE_VALID = 3'd4
    } state_t;

    localparam int c_idx_w = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_BYTES - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_idx_w-1:0]      r_byte_idx;
    // Holds the upper NB_DATA-N_BITS bits of the word being built; bytes
    // enter at the top and drift down, so the first byte ends up as the LSB.
    logic [NB_DATA-N_BITS-1:0] r_shift;
    logic [NB_DATA-1:0]      w_word;
    logic [NB_DATA-1:0]      r_instruction;
    logic [N_BITS-1:0]       r_count;
    logic [N_BITS-1:0]       r_words;
    logic [N_BITS-1:0]       w_words_next;
    logic [N_BITS-1:0]       r_mode;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_ready_num;
    logic                    r_full_pulse;
    logic                    r_all_sent;
    logic                    r_mode_ready;

    logic                    w_take_count;
    logic                    w_take_byte;
    logic                    w_word_done;
    logic                    w_last_word;
    logic                    w_take_mode;
    logic                    w_mode_clr;
`ifdef DU_RX_CHECKSUM_EN
    logic                    w_take_csum;
`endif

    assign w_word       = {i_rx_data, r_shift};
    assign w_words_next = r_words + 1'b1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= GET_COUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_take_count = 1'b0;
        w_take_byte  = 1'b0;
        w_word_done  = 1'b0;
        w_last_word  = 1'b0;
        w_take_mode  = 1'b0;
        w_mode_clr   = 1'b0;
`ifdef DU_RX_CHECKSUM_EN
        w_take_csum  = 1'b0;
`endif
        case (r_state)
            GET_COUNT: begin
                if (i_rx_done) begin
                    w_take_count = 1'b1;
                    w_next_state = (i_rx_data == '0) ? WAIT_MODE : GET_WORD;
                end
            end
            GET_WORD: begin
                if (i_rx_done) begin
                    w_take_byte = 1'b1;
                    if (r_byte_idx == c_last_idx) begin
                        w_word_done = 1'b1;
                        w_last_word = (w_words_next == r_count);
                        if (w_last_word) begin
`ifdef DU_RX_CHECKSUM_EN
                            w_next_state = CHECK;
`else
                            w_next_state = WAIT_MODE;
`endif
                        end
                    end
                end
            end
`ifdef DU_RX_CHECKSUM_EN
            CHECK: begin
                if (i_rx_done) begin
                    w_take_csum  = 1'b1;
                    w_next_state = WAIT_MODE;
                end
            end
`endif
            WAIT_MODE: begin
                if (i_rx_done) begin
                    w_take_mode  = 1'b1;
                    w_next_state = MODE_VALID;
                end
            end
            MODE_VALID: begin
                // Strobes are dropped here, including one that coincides
                // with the ack.
                if (i_mode_ack) begin
                    w_mode_clr   = 1'b1;
                    w_next_state = WAIT_MODE;
                end
            end
            default: w_next_state = GET_COUNT;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_byte_idx    <= '0;
            r_shift       <= '0;
            r_instruction <= '0;
            r_count       <= '0;
            r_words       <= '0;
            r_mode        <= '0;
            r_addr        <= '0;
            r_ready_num   <= 1'b0;
            r_full_pulse  <= 1'b0;
            r_all_sent    <= 1'b0;
            r_mode_ready  <= 1'b0;
        end else begin
            r_full_pulse <= 1'b0;
            if (w_take_count) begin
                r_count     <= i_rx_data;
                r_ready_num <= 1'b1;
                if (i_rx_data == '0) begin
                    r_all_sent <= 1'b1;
                end
            end
            if (w_take_byte) begin
                r_shift <= w_word[NB_DATA-1:N_BITS];
                if (w_word_done) begin
                    r_byte_idx <= '0;
                end else begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
            end
            if (w_word_done) begin
                r_instruction <= w_word;
                r_full_pulse  <= 1'b1;
                r_addr        <= r_addr + 1'b1;
                r_words       <= w_words_next;
                if (w_last_word) begin
                    r_all_sent <= 1'b1;
                end
            end
            if (w_take_mode) begin
                r_mode       <= i_rx_data;
                r_mode_ready <= 1'b1;
            end
            if (w_mode_clr) begin
                r_mode_ready <= 1'b0;
            end
        end
    end

`ifdef DU_RX_CHECKSUM_EN
    // Running XOR over instruction bytes only; the count byte is excluded.
    logic [N_BITS-1:0] r_csum;
    logic              r_error;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_csum  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_take_byte) begin
                r_csum <= r_csum ^ i_rx_data;
            end
            if (w_take_csum && (i_rx_data != r_csum)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    assign o_number_instructions  = r_count;
    assign o_ready_number_instr   = r_ready_num;
    assign o_instruction          = r_instruction;
    assign o_ready_full_inst      = r_full_pulse;
    assign o_addr_instruction     = r_addr;
    assign o_ready_all_instr_send = r_all_sent;
    assign o_mode_operate         = r_mode;
    assign o_ready_mode_operate   = r_mode_ready;
    assign o_state                = r_state;

endmodule

`default_nettype wire

// File: tb/tb_du_rx_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_du_rx_assembler
// Purpose  : Self-checking bench for du_rx_assembler. A byte-stream model
//            (count byte, instruction byte queue, optional checksum, mode
//            handshake) predicts every output each cycle; directed sequences
//            add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_du_rx_assembler;

    logic        i_clock;
    logic        i_reset;
    logic        i_rx_done;
    logic [7:0]  i_rx_data;
    logic        i_mode_ack;
    logic [7:0]  o_number_instructions;
    logic        o_ready_number_instr;
    logic [31:0] o_instruction;
    logic        o_ready_full_inst;
    logic [6:0]  o_addr_instruction;
    logic        o_ready_all_instr_send;
    logic [7:0]  o_mode_operate;
    logic        o_ready_mode_operate;
    logic        o_error;
    logic [2:0]  o_state;

    du_rx_assembler dut (
        .i_clock                (i_clock),
        .i_reset                (i_reset),
        .i_rx_done              (i_rx_done),
        .i_rx_data              (i_rx_data),
        .i_mode_ack             (i_mode_ack),
        .o_number_instructions  (o_number_instructions),
        .o_ready_number_instr   (o_ready_number_instr),
        .o_instruction          (o_instruction),
        .o_ready_full_inst      (o_ready_full_inst),
        .o_addr_instruction     (o_addr_instruction),
        .o_ready_all_instr_send (o_ready_all_instr_send),
        .o_mode_operate         (o_mode_operate),
        .o_ready_mode_operate   (o_ready_mode_operate),
        .o_error                (o_error),
        .o_state                (o_state)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the stream is count byte, 4*count instruction
    // bytes, [checksum byte], then mode bytes with a ready/ack handshake.
    // ------------------------------------------------------------------
    bit               m_have_cnt;
    int               m_cnt;
    byte unsigned     m_bytes[$];
    logic [7:0]       m_csum;
    bit               m_csum_done;
    int               m_phase;
    int               m_w;
    bit               m_old_rdy;

    logic [7:0]  e_num;
    logic        e_rdy_num;
    logic [31:0] e_instr;
    logic        e_pulse;
    logic [6:0]  e_addr;
    logic        e_all;
    logic [7:0]  e_mode;
    logic        e_mode_rdy;
    logic        e_err;

    // 0 count, 1 instruction bytes, 2 checksum, 3 mode
    function automatic int phase();
        if (!m_have_cnt) return 0;
        if (m_bytes.size() < 4 * m_cnt) return 1;
`ifdef DU_RX_CHECKSUM_EN
        if (!m_csum_done) return 2;
`endif
        return 3;
    endfunction

    function automatic logic [31:0] exp_state();
        int p;
        p = phase();
        if (p == 3) return e_mode_rdy ? 32'd4 : 32'd3;
        return 32'(p);
    endfunction

    always @(posedge i_clock) begin
        if (!i_reset) begin
            m_have_cnt  = 1'b0;
            m_cnt       = 0;
            m_bytes.delete();
            m_csum      = 8'h00;
            m_csum_done = 1'b0;
            e_num = 8'h00; e_rdy_num = 1'b0; e_instr = 32'h0; e_pulse = 1'b0;
            e_addr = 7'h00; e_all = 1'b0; e_mode = 8'h00; e_mode_rdy = 1'b0;
            e_err = 1'b0;
        end else begin
            m_phase   = phase();
            m_old_rdy = e_mode_rdy;
            e_pulse   = 1'b0;
            case (m_phase)
                0: if (i_rx_done) begin
                    m_cnt      = int'(i_rx_data);
                    m_have_cnt = 1'b1;
                    e_num      = i_rx_data;
                    e_rdy_num  = 1'b1;
                    if (i_rx_data == 8'h00) e_all = 1'b1;
                end
                1: if (i_rx_done) begin
                    m_bytes.push_back(i_rx_data);
                    m_csum = m_csum ^ i_rx_data;
                    if (m_bytes.size() % 4 == 0) begin
                        m_w     = m_bytes.size() / 4;
                        e_instr = {m_bytes[4*m_w-1], m_bytes[4*m_w-2],
                                   m_bytes[4*m_w-3], m_bytes[4*m_w-4]};
                        e_pulse = 1'b1;
                        e_addr  = 7'(m_w);
                        if (m_w == m_cnt) e_all = 1'b1;
                    end
                end
                2: if (i_rx_done) begin
                    if (i_rx_data != m_csum) e_err = 1'b1;
                    m_csum_done = 1'b1;
                end
                default: begin
                    if (m_old_rdy) begin
                        if (i_mode_ack) e_mode_rdy = 1'b0;
                    end else if (i_rx_done) begin
                        e_mode     = i_rx_data;
                        e_mode_rdy = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge i_clock) begin
        if (cmp_en) begin
            chk("num_instr",  32'(o_number_instructions),  32'(e_num));
            chk("rdy_num",    32'(o_ready_number_instr),   32'(e_rdy_num));
            chk("instr",      o_instruction,               e_instr);
            chk("full_pulse", 32'(o_ready_full_inst),      32'(e_pulse));
            chk("addr",       32'(o_addr_instruction),     32'(e_addr));
            chk("all_sent",   32'(o_ready_all_instr_send), 32'(e_all));
            chk("mode",       32'(o_mode_operate),         32'(e_mode));
            chk("mode_rdy",   32'(o_ready_mode_operate),   32'(e_mode_rdy));
            chk("error",      32'(o_error),                32'(e_err));
            chk("state",      32'(o_state),                exp_state());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after an edge and every
    // helper returns 1 time unit after the posedge that sampled it.
    // ------------------------------------------------------------------
    task automatic cyc(input bit rd, input logic [7:0] d, input bit ak);
        @(negedge i_clock); #1;
        i_rx_done  = rd;
        i_rx_data  = d;
        i_mode_ack = ak;
        @(posedge i_clock); #1;
        i_rx_done  = 1'b0;
        i_mode_ack = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clock); #1;
            i_reset   = 1'b0;
            i_rx_done = 1'b1;
            i_rx_data = 8'($urandom);
            @(posedge i_clock); #1;
        end
        i_rx_done = 1'b0;
        i_reset   = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         rd;
        bit         ak;
        logic [7:0] d;
        int         ncyc;

        i_reset = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00; i_mode_ack = 1'b0;

        // Reset held three cycles with strobes active
        do_reset(3);
        chk("rst_num",      32'(o_number_instructions),  32'h0);
        chk("rst_rdy_num",  32'(o_ready_number_instr),   32'h0);
        chk("rst_instr",    o_instruction,               32'h0);
        chk("rst_pulse",    32'(o_ready_full_inst),      32'h0);
        chk("rst_addr",     32'(o_addr_instruction),     32'h0);
        chk("rst_all",      32'(o_ready_all_instr_send), 32'h0);
        chk("rst_mode",     32'(o_mode_operate),         32'h0);
        chk("rst_mode_rdy", 32'(o_ready_mode_operate),   32'h0);
        chk("rst_err",      32'(o_error),                32'h0);
        chk("rst_state",    32'(o_state),                32'h0);
        cmp_en = 1'b1;

        // Count 2, two back-to-back words
        send(8'h02);
        chk("cnt_val", 32'(o_number_instructions), 32'h2);
        chk("cnt_rdy", 32'(o_ready_number_instr),  32'h1);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk("w1_pulse", 32'(o_ready_full_inst),      32'h1);
        chk("w1_instr", o_instruction,               32'h12345678);
        chk("w1_addr",  32'(o_addr_instruction),     32'h1);
        chk("w1_all",   32'(o_ready_all_instr_send), 32'h0);
        send(8'hEF);
        chk("w1_pulse_end", 32'(o_ready_full_inst), 32'h0);
        send(8'hBE); send(8'hAD); send(8'hDE);
        chk("w2_pulse", 32'(o_ready_full_inst),      32'h1);
        chk("w2_instr", o_instruction,               32'hDEADBEEF);
        chk("w2_addr",  32'(o_addr_instruction),     32'h2);
        chk("w2_all",   32'(o_ready_all_instr_send), 32'h1);
`ifdef DU_RX_CHECKSUM_EN
        send(8'h2A);
        chk("w2_csum_ok", 32'(o_error), 32'h0);
`endif
        // Mode handshake
        send(8'h10);
        chk("mode1_rdy",   32'(o_ready_mode_operate), 32'h1);
        chk("mode1_val",   32'(o_mode_operate),       32'h10);
        chk("mode1_state", 32'(o_state),              32'h4);
        send(8'h04);
        chk("mode_hold", 32'(o_mode_operate), 32'h10);
        cyc(1'b0, 8'h00, 1'b1);
        chk("ack_rdy",   32'(o_ready_mode_operate), 32'h0);
        chk("ack_state", 32'(o_state),              32'h3);
        send(8'h04);
        chk("mode2_val", 32'(o_mode_operate),       32'h04);
        chk("mode2_rdy", 32'(o_ready_mode_operate), 32'h1);
        cyc(1'b1, 8'h55, 1'b1);
        chk("ackwin_rdy", 32'(o_ready_mode_operate), 32'h0);
        chk("ackwin_val", 32'(o_mode_operate),       32'h04);

        // Count 0 goes straight to the mode byte
        do_reset(1);
        send(8'h00);
        chk("c0_all", 32'(o_ready_all_instr_send), 32'h1);
        send(8'h04);
        chk("c0_mode_rdy", 32'(o_ready_mode_operate), 32'h1);
        chk("c0_mode",     32'(o_mode_operate),       32'h04);

        // Reset in the middle of a word
        do_reset(1);
        send(8'h01); send(8'h01); send(8'h00);
        do_reset(1);
        chk("midrst_state", 32'(o_state), 32'h0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("midrst_pulse", 32'(o_ready_full_inst), 32'h0);
        send(8'h01);
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        chk("midrst_instr", o_instruction,           32'h00000001);
        chk("midrst_addr",  32'(o_addr_instruction), 32'h1);

`ifdef DU_RX_CHECKSUM_EN
        do_reset(1);
        send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h04);
        chk("csum_good_err", 32'(o_error), 32'h0);
        do_reset(1);
        send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05);
        chk("csum_bad_err", 32'(o_error), 32'h1);
        send(8'h33);
        chk("csum_bad_mode", 32'(o_mode_operate),       32'h33);
        chk("csum_bad_rdy",  32'(o_ready_mode_operate), 32'h1);
        chk("csum_sticky",   32'(o_error),              32'h1);
`endif

        // Randomised streams; iteration 5 uses 130 words to wrap the address
        for (int it = 0; it < 30; it++) begin
            do_reset($urandom_range(1, 3));
            ncyc = (it == 5) ? 1200 : $urandom_range(40, 300);
            for (int c = 0; c < ncyc; c++) begin
                rd = ($urandom % 3) != 0;
                d  = 8'($urandom);
                ak = ($urandom % 4) == 0;
                if (!m_have_cnt) d = (it == 5) ? 8'd130 : 8'($urandom_range(0, 6));
`ifdef DU_RX_CHECKSUM_EN
                if (phase() == 2 && ($urandom % 2) == 1) d = m_csum;
`endif
                cyc(rd, d, ak);
            end
        end

        @(negedge i_clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
